// File: rtl/i2s_in.sv
// I2S slave receiver: resynchronises an external bclk/lrclk/data triple into clk,
// deserialises each slot and presents 16-bit stereo pairs with lock and error flags.
module i2s_in #(
  parameter int AUDIO_DW    = 16,
  parameter int LOCK_FRAMES = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i2s_bclk,
  input  logic                i2s_lrclk,
  input  logic                i2s_data,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_ce,
  output logic                locked,
  output logic                err
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_HUNT, S_LEFT, S_RIGHT} state_t;

  function automatic logic [5:0] sat_cnt(input logic [5:0] c);
    return (c == 6'd63) ? c : c + 6'd1;
  endfunction

  function automatic logic [GW-1:0] sat_good(input logic [GW-1:0] g);
    return (g >= GW'(LOCK_FRAMES)) ? GW'(LOCK_FRAMES) : g + GW'(1);
  endfunction

  function automatic logic slot_bad(input logic [5:0] n);
    return (n < 6'd16) || (n > 6'd32);
  endfunction

  logic          r_bclk_s1, r_bclk_s2, r_bclk_s3;
  logic          r_lr_s1, r_lr_s2;
  logic          r_d_s1, r_d_s2;

  state_t        r_state;
  logic [5:0]    r_cnt;
  logic          r_lr_prev;
  logic [31:0]   r_sh;
  logic [31:0]   r_lword;
  logic [31:0]   r_rword;
  logic [5:0]    r_nl;
  logic [5:0]    r_nr;
  logic          r_have_l;
  logic [TW-1:0] r_idle;
  logic          r_expired;
  logic          r_vld_p0;
  logic          r_wd_p0;
  logic [GW-1:0] r_goodcnt;

  logic          w_rise;
  logic          w_bnd;
  logic [5:0]    w_cnt_nx;
  logic [4:0]    w_pos;
  logic [31:0]   w_sh_nx;
  logic          w_frame_err;
  logic [GW-1:0] w_good_nx;

  // Stage s1..s3: synchronise the serial bus into clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_s3 <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_d_s1    <= 1'b0;
      r_d_s2    <= 1'b0;
    end else begin
      r_bclk_s1 <= i2s_bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_s3 <= r_bclk_s2;
      r_lr_s1   <= i2s_lrclk;
      r_lr_s2   <= r_lr_s1;
      r_d_s1    <= i2s_data;
      r_d_s2    <= r_d_s1;
    end
  end

  assign w_rise   = r_bclk_s2 & ~r_bclk_s3;
  assign w_bnd    = w_rise & (r_lr_s2 != r_lr_prev);
  assign w_cnt_nx = sat_cnt(r_cnt);
  assign w_pos    = 5'(6'd32 - w_cnt_nx);

  always_comb begin
    w_sh_nx = r_sh;
    if ((r_state != S_HUNT) && (w_cnt_nx <= 6'd32))
      w_sh_nx[w_pos] = r_d_s2;
  end

  // Stage p0: slot deserialiser, framing state machine and watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_HUNT;
      r_cnt     <= 6'd0;
      r_lr_prev <= 1'b0;
      r_sh      <= 32'd0;
      r_lword   <= 32'd0;
      r_rword   <= 32'd0;
      r_nl      <= 6'd0;
      r_nr      <= 6'd0;
      r_have_l  <= 1'b0;
      r_idle    <= '0;
      r_expired <= 1'b0;
      r_vld_p0  <= 1'b0;
      r_wd_p0   <= 1'b0;
    end else begin
      r_vld_p0 <= 1'b0;
      r_wd_p0  <= 1'b0;
      if (w_rise) begin
        r_idle    <= '0;
        r_expired <= 1'b0;
        r_lr_prev <= r_lr_s2;
        if (w_bnd) begin
          r_cnt <= 6'd0;
          r_sh  <= 32'd0;
          case (r_state)
            S_HUNT: begin
              r_have_l <= 1'b0;
              r_state  <= r_lr_s2 ? S_RIGHT : S_LEFT;
            end
            S_LEFT: begin
              r_lword  <= w_sh_nx;
              r_nl     <= w_cnt_nx;
              r_have_l <= 1'b1;
              r_state  <= S_RIGHT;
            end
            default: begin
              r_rword  <= w_sh_nx;
              r_nr     <= w_cnt_nx;
              r_vld_p0 <= r_have_l;
              r_state  <= S_LEFT;
            end
          endcase
        end else begin
          r_cnt <= w_cnt_nx;
          r_sh  <= w_sh_nx;
        end
      end else if (!r_expired) begin
        // Expiry fires once; r_expired holds it off until bclk returns
        if (r_idle == TW'(TIMEOUT - 1)) begin
          r_expired <= 1'b1;
          r_wd_p0   <= 1'b1;
          r_state   <= S_HUNT;
          r_have_l  <= 1'b0;
          r_cnt     <= 6'd0;
          r_sh      <= 32'd0;
        end else begin
          r_idle <= r_idle + TW'(1);
        end
      end
    end
  end

  assign w_frame_err = slot_bad(r_nl) | slot_bad(r_nr) | (r_nl != r_nr);
  assign w_good_nx   = sat_good(r_goodcnt);

  // Stage p1: registered outputs, lock tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_chan  <= '0;
      right_chan <= '0;
      sample_ce  <= 1'b0;
      err        <= 1'b0;
      locked     <= 1'b0;
      r_goodcnt  <= '0;
    end else begin
      sample_ce <= 1'b0;
      err       <= 1'b0;
      if (r_vld_p0) begin
        left_chan  <= r_lword[31 -: AUDIO_DW];
        right_chan <= r_rword[31 -: AUDIO_DW];
        sample_ce  <= 1'b1;
        if (w_frame_err) begin
          err       <= 1'b1;
          r_goodcnt <= '0;
          locked    <= 1'b0;
        end else begin
          r_goodcnt <= w_good_nx;
          locked    <= (w_good_nx >= GW'(LOCK_FRAMES));
        end
      end else if (r_wd_p0) begin
        err       <= 1'b1;
        r_goodcnt <= '0;
        locked    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_in.sv
// Bench for i2s_in: drives I2S frames at bit level, predicts each output pair
// from the slot contents and lengths, and compares on every clk.
module tb_i2s_in;

  localparam int LOCKN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        sdata = 1'b0;
  logic [15:0] left_chan, right_chan;
  logic        sample_ce, locked, err;

  i2s_in #(.AUDIO_DW(16), .LOCK_FRAMES(LOCKN), .TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_data(sdata),
    .left_chan(left_chan), .right_chan(right_chan), .sample_ce(sample_ce),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        e;
    logic        lk;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   wd_errs = 0;
  int   mgood = 0;
  bit   wd_window = 1'b0;
  logic prev_bit = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Top 16 bits of what the receiver can see when only n MSBs are sent
  function automatic logic [15:0] top16(input logic [31:0] w, input int n);
    logic [31:0] t;
    t = (n >= 32) ? w : (w & ~(32'hFFFF_FFFF >> n));
    return t[31:16];
  endfunction

  function automatic bit slot_ok(input int n);
    return (n >= 16) && (n <= 32);
  endfunction

  task automatic bit_period(input logic lr, input logic d);
    bclk = 1'b0; lrclk = lr; sdata = d;
    #40;
    bclk = 1'b1;
    #40;
  endtask

  // One slot of n bclk periods; data lags lrclk by one bit
  task automatic send_slot(input logic ch, input int n, input logic [31:0] w);
    logic d;
    for (int j = 0; j < n; j++) begin
      if (j == 0) d = prev_bit;
      else        d = w[32-j];
      bit_period(ch, d);
    end
    prev_bit = w[32-n];
  endtask

  task automatic send_frame(input logic [31:0] lw, input int nl, input logic [31:0] rw,
                            input int nr, input bit produces);
    exp_t x;
    if (produces) begin
      x.l = top16(lw, nl);
      x.r = top16(rw, nr);
      x.e = !slot_ok(nl) || !slot_ok(nr) || (nl != nr);
      if (x.e) mgood = 0;
      else if (mgood < LOCKN) mgood++;
      x.lk = (mgood >= LOCKN);
      expq.push_back(x);
    end
    send_slot(1'b0, nl, lw);
    send_slot(1'b1, nr, rw);
  endtask

  // A fresh run starts in hunt: its first L/R pair never reaches the outputs
  task automatic run_frames(input logic [31:0] lw, input int nl, input logic [31:0] rw,
                            input int nr, input int count, input bit fresh);
    for (int i = 0; i < count; i++)
      send_frame(lw, nl, rw, nr, !(fresh && (i == 0)));
  endtask

  task automatic trailer();
    send_slot(1'b0, 4, 32'h0);
    @(negedge clk);
  endtask

  task automatic stall();
    wd_window = 1'b1;
    wd_errs = 0;
    repeat (1100) @(negedge clk);
    check("wd_err_count", 32'(wd_errs), 32'd1);
    check("wd_locked", 32'(locked), 32'd0);
    check("wd_drained", 32'(expq.size()), 32'd0);
    wd_window = 1'b0;
    mgood = 0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (sample_ce) begin
            if (expq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_ce: sample_ce=1 with no frame due");
            end else begin
              cur = expq.pop_front();
              check("left", 32'(left_chan), 32'(cur.l));
              check("right", 32'(right_chan), 32'(cur.r));
              check("err", 32'(err), 32'(cur.e));
              check("locked", 32'(locked), 32'(cur.lk));
            end
          end else if (err) begin
            if (wd_window) wd_errs++;
            else begin
              checks++; errors++;
              $display("FAIL stray_err: err=1 without sample_ce or stall");
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_left", 32'(left_chan), 32'd0);
    check("rst_right", 32'(right_chan), 32'd0);
    check("rst_ce", 32'(sample_ce), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    run_frames(32'h1234_0000, 16, 32'hABCD_0000, 16, 6, 1'b1);
    trailer();
    check("lit16_left", 32'(left_chan), 32'h1234);
    check("lit16_right", 32'(right_chan), 32'hABCD);
    check("lit16_locked", 32'(locked), 32'd1);
    stall();

    run_frames(32'h89AB_CDEF, 32, 32'h7FFF_0001, 32, 6, 1'b1);
    trailer();
    check("lit32_left", 32'(left_chan), 32'h89AB);
    check("lit32_right", 32'(right_chan), 32'h7FFF);
    check("lit32_locked", 32'(locked), 32'd1);
    stall();

    run_frames(32'hABC0_0000, 12, 32'h1230_0000, 12, 4, 1'b1);
    trailer();
    check("lit12_left", 32'(left_chan), 32'hABC0);
    check("lit12_locked", 32'(locked), 32'd0);
    stall();

    run_frames(32'h1234_0000, 16, 32'hABCD_0000, 16, 6, 1'b1);
    run_frames(32'h1111_0000, 16, 32'h5A5A_5A00, 24, 2, 1'b0);
    trailer();
    check("litmm_left", 32'(left_chan), 32'h1111);
    check("litmm_right", 32'(right_chan), 32'h5A5A);
    check("litmm_locked", 32'(locked), 32'd0);
    stall();

    run_frames(32'h0F0F_0000, 16, 32'hF0F0_0000, 16, 3, 1'b1);
    send_slot(1'b0, 16, 32'h0F0F_0000);
    send_slot(1'b1, 8, 32'hF0F0_0000);
    bclk = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_left", 32'(left_chan), 32'h0F0F);
    reset = 1'b1;
    #1;
    check("mid_rst_left", 32'(left_chan), 32'd0);
    check("mid_rst_right", 32'(right_chan), 32'd0);
    check("mid_rst_ce", 32'(sample_ce), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_drained", 32'(expq.size()), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mgood = 0;

    run_frames(32'h7FFF_0000, 16, 32'h8000_0000, 16, 4, 1'b1);
    trailer();
    repeat (2) @(negedge clk);
    check("post_rst_left", 32'(left_chan), 32'h7FFF);
    check("post_rst_right", 32'(right_chan), 32'h8000);
    check("post_rst_locked", 32'(locked), 32'd0);
    check("final_drained", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
